// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: EX/MEM and MEM/WB registers, control bundle,
// memory-access encodings and the MEM-stage FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned BE_WIDTH       = XLEN / 8;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_mem_e;

  // Store encodings share values with the signed loads.
  localparam funct3_mem_e F3_SB = F3_LB;
  localparam funct3_mem_e F3_SH = F3_LH;
  localparam funct3_mem_e F3_SW = F3_LW;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RSP} mem_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           rs2_data_str;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ctrl_t                     ctrl;
    logic                      valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [XLEN-1:0]           alu_result;
    logic [XLEN-1:0]           load_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ctrl_t                     ctrl;
    logic                      valid_mem_wb;
  } mem_wb_reg_t;

  // 011 and 11x fall through to word accesses.
  function automatic mem_size_e mem_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: valid/ready request channel plus a valid-qualified response.
interface mem_stage_if;
  import riscv_pkg::*;

  logic                dmem_req_valid;
  logic                dmem_req_ready;
  logic                dmem_req_we;
  logic [XLEN-1:0]     dmem_req_addr;
  logic [XLEN-1:0]     dmem_req_wdata;
  logic [BE_WIDTH-1:0] dmem_req_be;
  logic                dmem_rsp_valid;
  logic [XLEN-1:0]     dmem_rsp_rdata;
  logic                dmem_rsp_err;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational load/store alignment: store lane replication and byte enables,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]          off,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     rs2,
  input  logic [XLEN-1:0]     rdata,
  output logic [XLEN-1:0]     wdata,
  output logic [BE_WIDTH-1:0] be,
  output logic [XLEN-1:0]     load_data,
  output logic                misaligned
);

  mem_size_e       size;
  logic [XLEN-1:0] shifted;
  logic            sext;

  always_comb begin
    size       = mem_size(funct3);
    shifted    = rdata >> {off, 3'b000};
    sext       = ~funct3[2];
    wdata      = rs2;
    be         = '1;
    load_data  = shifted;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wdata     = {BE_WIDTH{rs2[7:0]}};
        be        = BE_WIDTH'(1) << off;
        load_data = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wdata      = {(BE_WIDTH/2){rs2[15:0]}};
        be         = BE_WIDTH'(3) << off;
        load_data  = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
        misaligned = off[0];
      end
      default: misaligned = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: drives the data-memory handshake, stalls the pipeline
// while an access is outstanding, and produces the MEM/WB register.
module mem_stage
  import riscv_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  ex_mem_reg_t               ex_mem_in,
  mem_stage_if.master               dmem,
  output logic [XLEN-1:0]           mem_alu_result,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                      mem_reg_write,
  output logic                      mem_stall,
  output logic                      mem_misaligned,
  output logic                      mem_access_fault,
  output mem_wb_reg_t               mem_wb_out
);

  mem_state_e      state, state_next;
  logic            access, misaligned_raw, req_valid, stall;
  logic [XLEN-1:0] load_fmt;
  mem_wb_reg_t     wb_next;

  lsu_align u_align (
    .off        (ex_mem_in.alu_result[1:0]),
    .funct3     (ex_mem_in.ctrl.mem_funct3),
    .rs2        (ex_mem_in.rs2_data_str),
    .rdata      (dmem.dmem_rsp_rdata),
    .wdata      (dmem.dmem_req_wdata),
    .be         (dmem.dmem_req_be),
    .load_data  (load_fmt),
    .misaligned (misaligned_raw)
  );

  assign dmem.dmem_req_we   = ex_mem_in.ctrl.mem_write;
  assign dmem.dmem_req_addr = {ex_mem_in.alu_result[XLEN-1:2], 2'b00};

  // Loads are never forwarded from MEM; the hazard unit handles load-use.
  assign mem_alu_result = ex_mem_in.alu_result;
  assign mem_rd_addr    = ex_mem_in.rd_addr;
  assign mem_reg_write  = ex_mem_in.valid_ex_mem & ex_mem_in.ctrl.reg_write
                        & ~ex_mem_in.ctrl.mem_read;

  always_comb begin
    access     = ex_mem_in.valid_ex_mem & (ex_mem_in.ctrl.mem_read | ex_mem_in.ctrl.mem_write);
    state_next = state;
    req_valid  = 1'b0;
    stall      = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (access && !misaligned_raw) begin
          req_valid  = 1'b1;
          stall      = 1'b1;
          state_next = dmem.dmem_req_ready ? MEM_RSP : MEM_REQ;
        end
      end
      MEM_REQ: begin
        req_valid = 1'b1;
        stall     = 1'b1;
        if (dmem.dmem_req_ready) state_next = MEM_RSP;
      end
      MEM_RSP: begin
        stall = ~dmem.dmem_rsp_valid;
        if (dmem.dmem_rsp_valid) state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase
    // Combinational outputs are forced quiet while reset is held.
    dmem.dmem_req_valid = reset & req_valid;
    mem_stall           = reset & stall;
    mem_misaligned      = reset & (state == MEM_IDLE) & access & misaligned_raw;
    mem_access_fault    = reset & (state == MEM_RSP) & dmem.dmem_rsp_valid & dmem.dmem_rsp_err;
  end

  always_comb begin
    wb_next                = '0;
    wb_next.alu_result     = ex_mem_in.alu_result;
    wb_next.rd_addr        = ex_mem_in.rd_addr;
    wb_next.ctrl           = ex_mem_in.ctrl;
    wb_next.ctrl.reg_write = ex_mem_in.ctrl.reg_write & ~mem_access_fault;
    wb_next.load_data      = ex_mem_in.ctrl.mem_read ? load_fmt : '0;
    wb_next.valid_mem_wb   = ex_mem_in.valid_ex_mem & ~mem_misaligned & ~mem_access_fault;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= MEM_IDLE;
      mem_wb_out <= '0;
    end else begin
      state <= state_next;
      if (mem_stall) mem_wb_out.valid_mem_wb <= 1'b0;
      else           mem_wb_out              <= wb_next;
    end
  end

endmodule
